// File: rtl/pwm_pkg.sv
// Shared types and cycle constants for the duty-cycle button conditioning path.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

  // 100 MHz FPGA build
  localparam int unsigned DEBOUNCE_CYCLES_FPGA     = 2000000;
  localparam int unsigned REPEAT_DELAY_CYCLES_FPGA = 50000000;
  localparam int unsigned REPEAT_RATE_CYCLES_FPGA  = 25000000;

  // Scaled-down values for simulation
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
  localparam int unsigned REPEAT_DELAY_CYCLES_SIM = 20;
  localparam int unsigned REPEAT_RATE_CYCLES_SIM  = 8;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/duty_button_ctrl_if.sv
// Button inputs and conditioned pulse/level outputs of duty_button_ctrl.
interface duty_button_ctrl_if;
  logic increase_duty;
  logic decrease_duty;
  logic duty_inc;
  logic duty_dec;
  logic inc_held;
  logic dec_held;

  modport master (
    output increase_duty, decrease_duty,
    input  duty_inc, duty_dec, inc_held, dec_held
  );

  modport slave (
    input  increase_duty, decrease_duty,
    output duty_inc, duty_dec, inc_held, dec_held
  );
endinterface

// File: rtl/btn_conditioner.sv
// One button channel: 2-FF synchronizer, counter debounce and press/hold/auto-repeat FSM.
// pulse is combinational; the caller registers it.
module btn_conditioner import pwm_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_FPGA,
  parameter int unsigned REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_FPGA,
  parameter int unsigned REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_FPGA,
  parameter int unsigned REPEAT_EN           = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX   = '1;
  localparam bit            REP       = (REPEAT_EN != 0);

  logic          sync1, sync2, stable;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  btn_state_t    state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != stable) begin
        if (cnt == DB_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // any agreeing sample restarts the filter
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (stable) begin
            state <= DELAY;
            timer <= '0;
          end
        end
        DELAY: begin
          if (!stable) begin
            state <= IDLE;
          end else if (REP && timer == DLY_LAST) begin
            state <= REPEAT;
            timer <= '0;
          end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!stable) begin
            state <= IDLE;
          end else if (timer == RATE_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pulse = 1'b0;
    unique case (state)
      IDLE:    pulse = stable;
      DELAY:   pulse = stable && REP && (timer == DLY_LAST);
      REPEAT:  pulse = stable && (timer == RATE_LAST);
      default: pulse = 1'b0;
    endcase
  end

  assign held = stable;

endmodule

// File: rtl/duty_button_ctrl.sv
// Two conditioned button channels plus arbitration and the registered duty pulses.
module duty_button_ctrl import pwm_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_FPGA,
  parameter int unsigned REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_FPGA,
  parameter int unsigned REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_FPGA,
  parameter int unsigned REPEAT_EN           = 1
) (
  input  logic               clk,
  input  logic               rst,
  duty_button_ctrl_if.slave  bus
);

  logic inc_stable, dec_stable;
  logic inc_pulse, dec_pulse;
  logic duty_inc_q, duty_dec_q;
  logic both_held;

  btn_conditioner #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (REPEAT_EN)
  ) u_inc (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.increase_duty),
    .held (inc_stable),
    .pulse(inc_pulse)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (REPEAT_EN)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.decrease_duty),
    .held (dec_stable),
    .pulse(dec_pulse)
  );

  // Both held: drop pulses outright so the PWM stage never sees a conflicting request
  assign both_held = inc_stable & dec_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_inc_q <= 1'b0;
      duty_dec_q <= 1'b0;
    end else begin
      duty_inc_q <= inc_pulse & ~both_held;
      duty_dec_q <= dec_pulse & ~both_held;
    end
  end

  assign bus.duty_inc = duty_inc_q;
  assign bus.duty_dec = duty_dec_q;
  assign bus.inc_held = inc_stable;
  assign bus.dec_held = dec_stable;

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Directed and random checks of duty_button_ctrl (repeat and no-repeat builds) against a timing model.
module tb_duty_button_ctrl;
  import pwm_pkg::*;

  localparam int DB   = DEBOUNCE_CYCLES_SIM;
  localparam int DLY  = REPEAT_DELAY_CYCLES_SIM;
  localparam int RATE = REPEAT_RATE_CYCLES_SIM;

  logic clk = 1'b0;
  logic rst = 1'b1;

  duty_button_ctrl_if bus_r ();
  duty_button_ctrl_if bus_n ();

  duty_button_ctrl #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES (RATE),
    .REPEAT_EN          (1)
  ) dut_r (
    .clk(clk),
    .rst(rst),
    .bus(bus_r)
  );

  duty_button_ctrl #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES (RATE),
    .REPEAT_EN          (0)
  ) dut_n (
    .clk(clk),
    .rst(rst),
    .bus(bus_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: index [c] = channel (0 inc, 1 dec); exp_p[r][c], r = 0 repeat build, 1 no-repeat
  logic          sync1_m [2];
  logic          sync2_m [2];
  logic [DB-1:0] hist_m  [2];
  logic          stable_m[2];
  int            age_m   [2];
  logic          exp_p   [2][2];

  int edge_no;
  int cnt_p[2][2];
  int first_edge[2][2];
  int dec_edges_r[$];

  function automatic bit fires(int age, bit rep);
    return (age == 0) || (rep && age >= DLY && ((age - DLY) % RATE) == 0);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      sync1_m[c] = 0; sync2_m[c] = 0; hist_m[c] = '0; stable_m[c] = 0; age_m[c] = 0;
      exp_p[0][c] = 0; exp_p[1][c] = 0;
    end
  endtask

  task automatic model_edge();
    logic st_pre[2];
    logic raw[2];
    logic both;
    raw[0] = bus_r.increase_duty;
    raw[1] = bus_r.decrease_duty;
    if (rst) begin
      model_clear();
      return;
    end
    for (int c = 0; c < 2; c++) st_pre[c] = stable_m[c];
    both = st_pre[0] & st_pre[1];
    for (int c = 0; c < 2; c++) begin
      exp_p[0][c] = st_pre[c] && fires(age_m[c], 1'b1) && !both;
      exp_p[1][c] = st_pre[c] && fires(age_m[c], 1'b0) && !both;
    end
    for (int c = 0; c < 2; c++) begin
      // level accepted once the last DB synced samples all disagree with it
      hist_m[c] = {hist_m[c][DB-2:0], sync2_m[c]};
      if (!st_pre[c] && (&hist_m[c])) begin
        stable_m[c] = 1'b1;
        age_m[c]    = 0;
      end else if (st_pre[c] && !(|hist_m[c])) begin
        stable_m[c] = 1'b0;
      end else if (st_pre[c]) begin
        age_m[c]++;
      end
      sync2_m[c] = sync1_m[c];
      sync1_m[c] = raw[c];
    end
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("r_duty_inc", bus_r.duty_inc, exp_p[0][0]);
    chk("r_duty_dec", bus_r.duty_dec, exp_p[0][1]);
    chk("r_inc_held", bus_r.inc_held, stable_m[0]);
    chk("r_dec_held", bus_r.dec_held, stable_m[1]);
    chk("n_duty_inc", bus_n.duty_inc, exp_p[1][0]);
    chk("n_duty_dec", bus_n.duty_dec, exp_p[1][1]);
    chk("n_inc_held", bus_n.inc_held, stable_m[0]);
    chk("n_dec_held", bus_n.dec_held, stable_m[1]);
    chk("r_exclusive", bus_r.duty_inc & bus_r.duty_dec, 1'b0);
  endtask

  task automatic clear_counts();
    edge_no = 0;
    dec_edges_r.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        cnt_p[r][c]      = 0;
        first_edge[r][c] = -1;
      end
  endtask

  task automatic note(int r, int c, logic p);
    if (p) begin
      cnt_p[r][c]++;
      if (first_edge[r][c] < 0) first_edge[r][c] = edge_no;
      if (r == 0 && c == 1) dec_edges_r.push_back(edge_no);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    check_all();
    note(0, 0, bus_r.duty_inc);
    note(0, 1, bus_r.duty_dec);
    note(1, 0, bus_n.duty_inc);
    note(1, 1, bus_n.duty_dec);
  endtask

  task automatic set_btn(logic inc, logic dec);
    bus_r.increase_duty = inc;
    bus_n.increase_duty = inc;
    bus_r.decrease_duty = dec;
    bus_n.decrease_duty = dec;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int exp_rep_edges[6] = '{7, 27, 35, 43, 51, 59};

  initial begin
    model_clear();
    clear_counts();
    set_btn(1'b0, 1'b0);

    // Reset held with buttons toggling
    #1;
    for (int i = 0; i < 10; i++) begin
      set_btn(i[0], ~i[0]);
      step();
    end
    set_btn(1'b0, 1'b0);
    step();
    rst = 1'b0;
    clear_counts();
    steps(10);
    chk_int("post_reset_pulses", cnt_p[0][0] + cnt_p[0][1], 0);

    // Clean press
    clear_counts();
    set_btn(1'b1, 1'b0);
    steps(12);
    set_btn(1'b0, 1'b0);
    steps(15);
    chk_int("clean_first_edge", first_edge[0][0], 7);
    chk_int("clean_inc_count", cnt_p[0][0], 1);
    chk_int("clean_dec_count", cnt_p[0][1], 0);

    // Bounce then settle high
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      set_btn(((i / 2) % 2) == 0, 1'b0);
      step();
    end
    chk_int("bounce_no_pulse", cnt_p[0][0], 0);
    clear_counts();
    set_btn(1'b1, 1'b0);
    steps(16);
    set_btn(1'b0, 1'b0);
    steps(12);
    chk_int("bounce_first_edge", first_edge[0][0], 7);
    chk_int("bounce_inc_count", cnt_p[0][0], 1);

    // Auto-repeat on decrease
    clear_counts();
    set_btn(1'b0, 1'b1);
    steps(60);
    set_btn(1'b0, 1'b0);
    steps(20);
    chk_int("rep_dec_count", dec_edges_r.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < dec_edges_r.size()) chk_int("rep_dec_edge", dec_edges_r[i], exp_rep_edges[i]);
    chk_int("norep_dec_count", cnt_p[1][1], 1);

    // Simultaneous press, then release increase only
    clear_counts();
    set_btn(1'b1, 1'b1);
    steps(40);
    chk_int("simul_inc", cnt_p[0][0] + cnt_p[1][0], 0);
    chk_int("simul_dec", cnt_p[0][1] + cnt_p[1][1], 0);
    chk("simul_held", bus_r.inc_held & bus_r.dec_held, 1'b1);
    cnt_p[0][1] = 0;
    set_btn(1'b0, 1'b1);
    steps(40);
    set_btn(1'b0, 1'b0);
    steps(15);
    chk_int("simul_resume_dec", cnt_p[0][1], 5);

    // Reset mid-REPEAT with the button still held
    set_btn(1'b0, 1'b1);
    steps(40);
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    steps(3);
    rst = 1'b0;
    clear_counts();
    steps(30);
    chk_int("rst_rep_first_edge", first_edge[0][1], 7);
    chk_int("rst_rep_count", cnt_p[0][1], 2);
    chk_int("rst_norep_first_edge", first_edge[1][1], 7);
    chk_int("rst_norep_count", cnt_p[1][1], 1);
    set_btn(1'b0, 1'b0);
    steps(15);

    // Random buttons with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 11) == 0) set_btn(~bus_r.increase_duty, bus_r.decrease_duty);
      if ($urandom_range(0, 11) == 0) set_btn(bus_r.increase_duty, ~bus_r.decrease_duty);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    steps(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
